// File: rtl/i2c_slave_byte_ctrl_pkg.sv
// Shared state encodings and line-level constants for the I2C byte target.
// Pure definitions, no logic.
package i2c_slave_byte_ctrl_pkg;

  typedef enum logic [7:0] {
    ST_IDLE     = 8'b0000_0001,
    ST_ADDR     = 8'b0000_0010,
    ST_ADDR_ACK = 8'b0000_0100,
    ST_RX       = 8'b0000_1000,
    ST_RX_ACK   = 8'b0001_0000,
    ST_TX       = 8'b0010_0000,
    ST_TX_ACK   = 8'b0100_0000,
    ST_WAIT     = 8'b1000_0000
  } state_e;

  localparam logic       ACK_LVL  = 1'b0;
  localparam logic       NACK_LVL = 1'b1;
  localparam logic [2:0] BIT_MSB  = 3'd7;

endpackage

// File: rtl/i2c_slave_line_sync.sv
// SCL/SDA synchroniser with one history stage; emits edge and START/STOP events.
// Events appear SYNC_STAGES+1 clocks after the pad change; no backpressure.
module i2c_slave_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_evt,
  output logic stop_evt
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic scl_hist_q, scl_hist_d;
  logic sda_hist_q, sda_hist_d;
  logic scl_s;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
    scl_hist_d = scl_s;
    sda_hist_d = sda_s;
  end

  // Reset to the idle-bus level so a reset never fabricates an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
    end
  end

  assign scl_rise  =  scl_s & ~scl_hist_q;
  assign scl_fall  = ~scl_s &  scl_hist_q;
  assign start_evt =  scl_s &  scl_hist_q &  sda_hist_q & ~sda_s;
  assign stop_evt  =  scl_s &  scl_hist_q & ~sda_hist_q &  sda_s;

endmodule

// File: rtl/i2c_slave_byte_ctrl.sv
// Byte-level I2C target: address match, write receive with ACK/NACK, read transmit.
// Outputs are registered one clock after the line event; no clock stretching.
module i2c_slave_byte_ctrl
  import i2c_slave_byte_ctrl_pkg::*;
#(
  parameter logic [6:0] SLV_ADDR    = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_oen,
  input  logic       ack_en,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rw,
  output logic       busy,
  output logic       start_det,
  output logic       stop_det
);

  logic sda_s, scl_rise, scl_fall, start_evt, stop_evt;

  i2c_slave_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_evt (start_evt),
    .stop_evt  (stop_evt)
  );

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       sda_oen_q, sda_oen_d;
  logic       tx_req_q, tx_req_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rw_q, rw_d;
  logic       busy_q, busy_d;
  logic       start_det_q, start_det_d;
  logic       stop_det_q, stop_det_d;
  logic       ack_ph_q, ack_ph_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    rx_data_d   = rx_data_q;
    sda_oen_d   = sda_oen_q;
    rw_d        = rw_q;
    busy_d      = busy_q;
    ack_ph_d    = ack_ph_q;
    tx_req_d    = 1'b0;
    rx_valid_d  = 1'b0;
    start_det_d = 1'b0;
    stop_det_d  = 1'b0;

    if (start_evt) begin
      state_d     = ST_ADDR;
      cnt_d       = BIT_MSB;
      sda_oen_d   = 1'b1;
      busy_d      = 1'b1;
      ack_ph_d    = 1'b0;
      start_det_d = 1'b1;
    end else if (stop_evt) begin
      state_d    = ST_IDLE;
      sda_oen_d  = 1'b1;
      busy_d     = 1'b0;
      ack_ph_d   = 1'b0;
      stop_det_d = 1'b1;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            sh_d = {sh_q[6:0], sda_s};
            if (cnt_q == 3'd0) begin
              // A foreign address parks in IDLE; busy stays up until STOP.
              if (sh_q[6:0] == SLV_ADDR) begin
                rw_d     = sda_s;
                ack_ph_d = 1'b0;
                state_d  = ST_ADDR_ACK;
              end else begin
                state_d = ST_IDLE;
              end
            end else begin
              cnt_d = cnt_q - 3'd1;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (!ack_ph_q) begin
              sda_oen_d = ACK_LVL;
              tx_req_d  = rw_q;
              ack_ph_d  = 1'b1;
            end else begin
              ack_ph_d = 1'b0;
              cnt_d    = BIT_MSB;
              if (rw_q) begin
                sh_d      = tx_data;
                sda_oen_d = tx_data[7];
                state_d   = ST_TX;
              end else begin
                sda_oen_d = 1'b1;
                state_d   = ST_RX;
              end
            end
          end
        end
        ST_RX: begin
          if (scl_rise) begin
            sh_d = {sh_q[6:0], sda_s};
            if (cnt_q == 3'd0) begin
              if (ack_en) begin
                rx_data_d  = {sh_q[6:0], sda_s};
                rx_valid_d = 1'b1;
              end
              ack_ph_d = 1'b0;
              state_d  = ST_RX_ACK;
            end else begin
              cnt_d = cnt_q - 3'd1;
            end
          end
        end
        ST_RX_ACK: begin
          if (scl_fall) begin
            if (!ack_ph_q) begin
              sda_oen_d = ~ack_en;
              ack_ph_d  = 1'b1;
            end else begin
              sda_oen_d = 1'b1;
              cnt_d     = BIT_MSB;
              ack_ph_d  = 1'b0;
              state_d   = ST_RX;
            end
          end
        end
        ST_TX: begin
          if (scl_fall) begin
            if (cnt_q == 3'd0) begin
              sda_oen_d = 1'b1;
              ack_ph_d  = 1'b0;
              state_d   = ST_TX_ACK;
            end else begin
              cnt_d     = cnt_q - 3'd1;
              sda_oen_d = sh_q[6];
              sh_d      = {sh_q[6:0], 1'b0};
            end
          end
        end
        ST_TX_ACK: begin
          // ack_ph separates the master's ACK sample from the following reload fall.
          if (!ack_ph_q && scl_rise) begin
            if (sda_s == ACK_LVL) begin
              tx_req_d = 1'b1;
              ack_ph_d = 1'b1;
            end else begin
              state_d = ST_WAIT;
            end
          end else if (ack_ph_q && scl_fall) begin
            sh_d      = tx_data;
            sda_oen_d = tx_data[7];
            cnt_d     = BIT_MSB;
            ack_ph_d  = 1'b0;
            state_d   = ST_TX;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= BIT_MSB;
      sh_q        <= 8'h00;
      rx_data_q   <= 8'h00;
      sda_oen_q   <= 1'b1;
      tx_req_q    <= 1'b0;
      rx_valid_q  <= 1'b0;
      rw_q        <= 1'b0;
      busy_q      <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
      ack_ph_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      rx_data_q   <= rx_data_d;
      sda_oen_q   <= sda_oen_d;
      tx_req_q    <= tx_req_d;
      rx_valid_q  <= rx_valid_d;
      rw_q        <= rw_d;
      busy_q      <= busy_d;
      start_det_q <= start_det_d;
      stop_det_q  <= stop_det_d;
      ack_ph_q    <= ack_ph_d;
    end
  end

  assign sda_o     = 1'b0;
  assign sda_oen   = sda_oen_q;
  assign tx_req    = tx_req_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rw        = rw_q;
  assign busy      = busy_q;
  assign start_det = start_det_q;
  assign stop_det  = stop_det_q;

endmodule
